// File: rtl/pio_initiator.sv
// PIO bus master: one host request at a time onto the shared reg_* slave bus; PIO_INIT_TIMEOUT_EN adds an ack timeout.
// Latency: accept->strobe 1 cycle, ack sample->rsp_valid 1 cycle; min request-to-request 4 cycles plus ack time.
// Backpressure: req_ready high only in IDLE; rsp_valid is a one-cycle strobe with no backpressure.

`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module pio_initiator #(
    parameter int NSLV      = 4,
    parameter int SEL_LSB   = 16,
    parameter int SEL_NBITS = 2,
    parameter int TMO_NBITS = 8
) (
    input  logic                        clk,
    input  logic                        `RESET_SIG,
    input  logic                        clk_div,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [`PIO_NBITS-1:0]       req_addr,
    input  logic [`PIO_NBITS-1:0]       req_wdata,
    output logic                        rsp_valid,
    output logic [`PIO_NBITS-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic [`PIO_NBITS-1:0]       reg_addr,
    output logic [`PIO_NBITS-1:0]       reg_din,
    output logic                        reg_rd,
    output logic                        reg_wr,
    output logic [NSLV-1:0]             reg_ms,
    input  logic [NSLV-1:0]             slv_ack,
    input  logic [NSLV*`PIO_NBITS-1:0]  slv_rdata
);

    localparam int DW = `PIO_NBITS;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        STROBE        = 2'd1,
        WAIT_ACK      = 2'd2,
        WAIT_DEASSERT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [SEL_NBITS-1:0]   sel_q, sel_d;
    logic [DW-1:0]          reg_addr_q, reg_addr_d;
    logic [DW-1:0]          reg_din_q, reg_din_d;
    logic                   reg_rd_q, reg_rd_d;
    logic                   reg_wr_q, reg_wr_d;
    logic [NSLV-1:0]        reg_ms_q, reg_ms_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DW-1:0]          rsp_rdata_q, rsp_rdata_d;

    logic [SEL_NBITS-1:0]   req_sel;
    logic                   req_unmapped;
    logic                   ack_sel;
    logic [DW-1:0]          rdata_sel;

    assign req_sel      = req_addr[SEL_LSB +: SEL_NBITS];
    assign req_unmapped = (int'(req_sel) >= NSLV);

    // Only the lane of the slave currently addressed is ever looked at.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SEL_NBITS'(i)) begin
                ack_sel   = slv_ack[i];
                rdata_sel = slv_rdata[i*DW +: DW];
            end
        end
    end

`ifdef PIO_INIT_TIMEOUT_EN
    logic [TMO_NBITS-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_expired;

    assign tmo_expired = &tmo_cnt_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == STROBE) begin
            tmo_cnt_d = '0;
        end else if (clk_div && !tmo_expired &&
                     (state_q == WAIT_ACK || state_q == WAIT_DEASSERT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam int unused_tmo_nbits = TMO_NBITS;
    logic unused_clk_div;
    assign unused_clk_div = clk_div;
`endif

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        sel_d       = sel_q;
        reg_addr_d  = reg_addr_q;
        reg_din_d   = reg_din_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_unmapped) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '1;
                    end else begin
                        wr_d       = req_wr;
                        sel_d      = req_sel;
                        reg_addr_d = req_addr;
                        reg_din_d  = req_wdata;
                        state_d    = STROBE;
                    end
                end
            end
            // An ack still high from the previous access is never sampled here.
            STROBE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_sel) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wr_q ? '0 : rdata_sel;
                    state_d     = WAIT_DEASSERT;
`ifdef PIO_INIT_TIMEOUT_EN
                end else if (tmo_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '1;
                    state_d     = IDLE;
`endif
                end
            end
            WAIT_DEASSERT: begin
                if (!ack_sel) begin
                    state_d = IDLE;
`ifdef PIO_INIT_TIMEOUT_EN
                end else if (tmo_expired) begin
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus controls are registered from the next state so they leave flops glitch-free.
        reg_rd_d = (state_d == STROBE) && !wr_d;
        reg_wr_d = (state_d == STROBE) && wr_d;
        reg_ms_d = '0;
        if (state_d == STROBE || state_d == WAIT_ACK) begin
            for (int i = 0; i < NSLV; i++) begin
                if (sel_d == SEL_NBITS'(i)) begin
                    reg_ms_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            reg_addr_q  <= '0;
            reg_din_q   <= '0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_ms_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
            reg_addr_q  <= reg_addr_d;
            reg_din_q   <= reg_din_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_ms_q    <= reg_ms_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign reg_addr  = reg_addr_q;
    assign reg_din   = reg_din_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_ms    = reg_ms_q;

endmodule
